// File: rtl/seven_seg_scan_decoder_if.sv
// Multiplexed 4-digit seven-segment bus (all lines active-low).
// The LED driver is the master; passive monitors take the slave view.
interface seven_seg_scan_decoder_if;
    logic an3;
    logic an2;
    logic an1;
    logic an0;
    logic led_a;
    logic led_b;
    logic led_c;
    logic led_d;
    logic led_e;
    logic led_f;
    logic led_g;
    logic dp;

    modport master (
        output an3, an2, an1, an0,
        output led_a, led_b, led_c, led_d, led_e, led_f, led_g,
        output dp
    );

    modport slave (
        input an3, an2, an1, an0,
        input led_a, led_b, led_c, led_d, led_e, led_f, led_g,
        input dp
    );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Passive monitor for a scanned 4-digit seven-segment bus: debounces each
// digit dwell, decodes segments back to hex and reassembles 16-bit frames.
module seven_seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                     clk,
    input  logic                     reset,
    seven_seg_scan_decoder_if.slave  bus,
    output logic [15:0]              frame,
    output logic [3:0]               dp_mask,
    output logic [3:0]               seg_err,
    output logic                     frame_valid,
    output logic                     scan_error,
    output logic                     stale
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]    SETTLE_MAX = 8'(SETTLE_CYCLES);
    localparam logic [7:0]    SETTLE_M1  = 8'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);

    logic [3:0]    r_an, p_an;
    logic [6:0]    r_seg, p_seg;
    logic          r_dp, p_dp;
    logic [7:0]    stable_cnt;
    logic          captured;
    logic [3:0]    seen;
    logic [15:0]   work_digit;
    logic [3:0]    work_dp;
    logic [3:0]    work_err;
    logic [TW-1:0] tmo_cnt;

    logic       changed;
    logic [3:0] an_low;
    logic       one_hot;
    logic       multi_low;
    logic [1:0] idx;
    logic       capture;
    logic [4:0] dec;
    logic [3:0] seen_nxt;

    // Returns {err, nibble}; segments arrive active-high in gfedcba order.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] d;
        case (s)
            7'h3F:   d = 5'h00;
            7'h06:   d = 5'h01;
            7'h5B:   d = 5'h02;
            7'h4F:   d = 5'h03;
            7'h66:   d = 5'h04;
            7'h6D:   d = 5'h05;
            7'h7D:   d = 5'h06;
            7'h07:   d = 5'h07;
            7'h7F:   d = 5'h08;
            7'h6F:   d = 5'h09;
            7'h77:   d = 5'h0A;
            7'h7C:   d = 5'h0B;
            7'h39:   d = 5'h0C;
            7'h5E:   d = 5'h0D;
            7'h79:   d = 5'h0E;
            7'h71:   d = 5'h0F;
            default: d = 5'h10;
        endcase
        return d;
    endfunction

    always_comb begin
        changed   = {r_an, r_seg, r_dp} != {p_an, p_seg, p_dp};
        an_low    = ~r_an;
        multi_low = (an_low & (an_low - 4'd1)) != 4'd0;
        one_hot   = (an_low != 4'd0) && !multi_low;
        idx       = 2'd0;
        case (an_low)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        capture = one_hot && !changed && !captured
                  && (stable_cnt == SETTLE_M1);
        dec      = decode(~r_seg);
        seen_nxt = (seen == 4'hF) ? 4'h0 : seen;
        if (capture) seen_nxt[idx] = 1'b1;
    end

    // Idle (all-high) is the cleared state of the active-low input register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= 4'hF;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
            p_an  <= 4'hF;
            p_seg <= 7'h7F;
            p_dp  <= 1'b1;
        end else begin
            r_an  <= {bus.an3, bus.an2, bus.an1, bus.an0};
            r_seg <= {bus.led_g, bus.led_f, bus.led_e, bus.led_d,
                      bus.led_c, bus.led_b, bus.led_a};
            r_dp  <= bus.dp;
            p_an  <= r_an;
            p_seg <= r_seg;
            p_dp  <= r_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_cnt  <= 8'd0;
            captured    <= 1'b0;
            seen        <= 4'h0;
            work_digit  <= 16'h0;
            work_dp     <= 4'h0;
            work_err    <= 4'h0;
            tmo_cnt     <= '0;
            frame       <= 16'h0;
            dp_mask     <= 4'h0;
            seg_err     <= 4'h0;
            frame_valid <= 1'b0;
            scan_error  <= 1'b0;
        end else begin
            if (changed) begin
                stable_cnt <= 8'd0;
                captured   <= 1'b0;
            end else begin
                if (stable_cnt != SETTLE_MAX) stable_cnt <= stable_cnt + 8'd1;
                if (capture) captured <= 1'b1;
            end
            if (capture) begin
                work_digit[idx*4 +: 4] <= dec[3:0];
                work_dp[idx]           <= ~r_dp;
                work_err[idx]          <= dec[4];
            end
            seen        <= seen_nxt;
            frame_valid <= (seen == 4'hF);
            if (seen == 4'hF) begin
                frame   <= work_digit;
                dp_mask <= work_dp;
                seg_err <= work_err;
            end
            scan_error <= multi_low;
            if (capture) tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign stale = (tmo_cnt == TMO_MAX);

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed and randomized scans against a dwell-level model of the
// seven-segment scan decoder.
module tb_seven_seg_scan_decoder;

    localparam int SETTLE = 4;
    localparam int TMO    = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] frame;
    logic [3:0]  dp_mask;
    logic [3:0]  seg_err;
    logic        frame_valid;
    logic        scan_error;
    logic        stale;

    always #5 clk = ~clk;

    seven_seg_scan_decoder_if bus ();

    seven_seg_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .frame      (frame),
        .dp_mask    (dp_mask),
        .seg_err    (seg_err),
        .frame_valid(frame_valid),
        .scan_error (scan_error),
        .stale      (stale)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fv_cnt = 0;
    int sc_cnt = 0;
    int sc_run = 0;
    int sc_max = 0;
    logic prev_fv = 1'b0;
    logic [23:0] exp_q[$];
    int fv_cyc[$];

    logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                             7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                             7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0] m_nib [4];
    logic [3:0] m_dp, m_err, m_seen;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [23:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (frame_valid) begin
            fv_cnt++;
            fv_cyc.push_back(cyc);
            check("fv_width", prev_fv, 1'b0);
            check("frame_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("frame_content", {seg_err, dp_mask, frame}, e);
            end
        end
        prev_fv = frame_valid;
        if (scan_error) begin
            sc_cnt++;
            sc_run++;
            if (sc_run > sc_max) sc_max = sc_run;
        end else begin
            sc_run = 0;
        end
    endtask

    task automatic set_pins(input logic [3:0] an, input logic [6:0] pat,
                            input logic dp_on);
        bus.an3   = an[3];
        bus.an2   = an[2];
        bus.an1   = an[1];
        bus.an0   = an[0];
        bus.led_a = ~pat[0];
        bus.led_b = ~pat[1];
        bus.led_c = ~pat[2];
        bus.led_d = ~pat[3];
        bus.led_e = ~pat[4];
        bus.led_f = ~pat[5];
        bus.led_g = ~pat[6];
        bus.dp    = ~dp_on;
    endtask

    function automatic logic [4:0] model_decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (tab[i] == p) return {1'b0, 4'(i)};
        return 5'h10;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
        m_dp = 4'h0;
        m_err = 4'h0;
        m_seen = 4'h0;
    endtask

    task automatic model_capture(input int d, input logic [6:0] pat,
                                 input logic dp_on);
        logic [4:0] dec;
        dec = model_decode(pat);
        m_nib[d] = dec[3:0];
        m_err[d] = dec[4];
        m_dp[d] = dp_on;
        m_seen[d] = 1'b1;
        if (m_seen == 4'hF) begin
            exp_q.push_back({m_err, m_dp, m_nib[3], m_nib[2],
                             m_nib[1], m_nib[0]});
            m_seen = 4'h0;
        end
    endtask

    task automatic dwell(input int d, input logic [6:0] pat,
                         input logic dp_on, input int len);
        logic [3:0] an;
        an = 4'hF;
        an[d] = 1'b0;
        if (len >= SETTLE + 1) model_capture(d, pat, dp_on);
        set_pins(an, pat, dp_on);
        repeat (len) step();
    endtask

    task automatic idle(input int n);
        set_pins(4'hF, 7'h00, 1'b0);
        repeat (n) step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_frame"}, frame, 0);
        check({tag, "_dp"}, dp_mask, 0);
        check({tag, "_err"}, seg_err, 0);
        check({tag, "_fv"}, frame_valid, 0);
        check({tag, "_scan"}, scan_error, 0);
        check({tag, "_stale"}, stale, 0);
    endtask

    initial begin
        int base;
        int prev_d;
        int d;
        int len;
        logic [6:0] pat;
        logic [3:0] an;

        model_clear();
        reset = 1'b1;
        idle(3);
        check_zero("reset");
        reset = 1'b0;

        // "1234" with 3-cycle dwells: never settles, timeout must fire
        for (int i = 0; i < 105; i++) begin
            d = 3 - (i / 3) % 4;
            an = 4'hF;
            an[d] = 1'b0;
            set_pins(an, tab[4 - d], d == 2);
            step();
            if (i == 98) check("stale_pre", stale, 0);
            if (i == 99) check("stale_at", stale, 1);
        end
        check("short_no_frame", fv_cnt, 0);

        // stale recovery via one good dwell on digit 0
        model_capture(0, tab[5], 1'b0);
        set_pins(4'b1110, tab[5], 1'b0);
        repeat (3) step();
        check("stale_hold", stale, 1);
        repeat (13) step();
        check("stale_clear", stale, 0);
        idle(4);
        check("recovery_no_frame", fv_cnt, 0);

        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        model_clear();

        // "1234", dp on digit 2, 16-cycle dwells
        base = fv_cnt;
        for (int r = 0; r < 3; r++)
            for (int k = 3; k >= 0; k--)
                dwell(k, tab[4 - k], k == 2, 16);
        idle(4);
        check("frames_1234", fv_cnt - base, 3);
        check("frame_1234", frame, 16'h1234);
        check("dp_1234", dp_mask, 4'b0100);
        check("err_1234", seg_err, 4'b0000);
        if (fv_cyc.size() >= base + 3) begin
            check("period_a", fv_cyc[base + 1] - fv_cyc[base], 64);
            check("period_b", fv_cyc[base + 2] - fv_cyc[base + 1], 64);
        end

        // two anodes low together
        sc_cnt = 0;
        sc_max = 0;
        set_pins(4'b1100, tab[6], 1'b0);
        repeat (5) step();
        idle(4);
        check("scan_err_cnt", sc_cnt, 5);
        check("scan_err_run", sc_max, 5);
        check("scan_err_no_frame", fv_cnt - base, 3);

        // unrecognised pattern (segment a only) on digit 0
        dwell(3, tab[9], 1'b0, 16);
        dwell(2, tab[8], 1'b0, 16);
        dwell(1, tab[7], 1'b0, 16);
        dwell(0, 7'h01, 1'b0, 16);
        idle(4);
        check("frame_9870", frame, 16'h9870);
        check("err_9870", seg_err, 4'b0001);

        // reset after two captures discards the partial frame
        dwell(3, tab[1], 1'b0, 16);
        dwell(2, tab[2], 1'b0, 16);
        reset = 1'b1;
        idle(1);
        check_zero("rst_mid");
        reset = 1'b0;
        model_clear();
        base = fv_cnt;
        dwell(1, tab[12], 1'b0, 16);
        dwell(0, tab[13], 1'b0, 16);
        idle(4);
        check("rst_mid_no_frame", fv_cnt - base, 0);
        dwell(3, tab[10], 1'b0, 16);
        dwell(2, tab[11], 1'b0, 16);
        idle(4);
        check("rst_mid_frames", fv_cnt - base, 1);
        check("frame_abcd", frame, 16'hABCD);

        // randomized dwells
        prev_d = -1;
        for (int i = 0; i < 60; i++) begin
            do d = int'($urandom_range(0, 3)); while (d == prev_d);
            prev_d = d;
            if ($urandom_range(0, 7) == 0) pat = 7'($urandom);
            else pat = tab[$urandom_range(0, 15)];
            len = ($urandom_range(0, 4) == 0) ? 3 : int'($urandom_range(6, 20));
            dwell(d, pat, 1'($urandom), len);
        end
        idle(6);
        check("rand_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
